// File: rtl/bb_v2_pkg.sv
// Shared state encoding and geometry for the 64x32 sram request sequencer.
package bb_v2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RDCAP   = 3'd2,
        ST_WR      = 3'd3,
        ST_RMW_RD  = 3'd4,
        ST_RMW_CAP = 3'd5,
        ST_RMW_WR  = 3'd6,
        ST_ACK     = 3'd7
    } state_t;

    localparam int V2_WORDS     = 64;
    localparam int V2_ADDR_BITS = $clog2(V2_WORDS);
    localparam int V2_REQ_AW    = 14;

    // Any request word-address bit above the implemented sram range is an error.
    localparam logic [V2_REQ_AW-1:0] V2_ERR_MASK = ~V2_REQ_AW'(V2_WORDS - 1);

endpackage

// File: rtl/bb_v2_merge.sv
// Byte-wise merge of sram read data with write data under byte enables.
// Purely combinational; no backpressure.
module bb_v2_merge (
    input  logic [31:0] old_dat,
    input  logic [31:0] new_dat,
    input  logic [3:0]  be,
    output logic [31:0] mrg_dat
);

    for (genvar n = 0; n < 4; n++) begin : g_byte
        assign mrg_dat[8*n +: 8] = be[n] ? new_dat[8*n +: 8] : old_dat[8*n +: 8];
    end

endmodule

// File: rtl/bb_v2_ctrl.sv
// Single-beat register-bus sequencer for the 64x32 sram; partial writes via read-modify-write.
// Latency: 1 clk write/ack, 2 clk read, 3 clk partial write; req_rdy only while idle.
module bb_v2_ctrl
    import bb_v2_pkg::*;
#(
    parameter int ADDR_BITS = V2_ADDR_BITS,
    parameter int ADDR_HI   = 15
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic                req_we,
    input  logic [ADDR_HI-2:0]  req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [3:0]          req_be,
    output logic                rsp_vld,
    output logic [31:0]         rsp_data,
    output logic                rsp_err,
    output logic                v_me,
    output logic                v_we,
    output logic [ADDR_HI-2:0]  v_addr,
    output logic [31:0]         v_in,
    input  logic [31:0]         v_out
);

    localparam int AW = ADDR_HI - 1;
    localparam logic [AW-1:0] ERR_MASK = ~AW'((1 << ADDR_BITS) - 1);

    state_t          state_q;
    state_t          state_d;
    logic            acc;
    logic            addr_err;

    logic            lat_we;
    logic            lat_err;
    logic [3:0]      lat_be;
    logic [31:0]     lat_wdata;

    logic            v_me_d;
    logic            v_we_d;
    logic [AW-1:0]   v_addr_d;
    logic [31:0]     v_in_d;
    logic            rsp_vld_d;
    logic            rsp_err_d;
    logic [31:0]     rsp_data_d;
    logic [31:0]     mrg_dat;

    assign req_rdy  = (state_q == ST_IDLE);
    assign acc      = req_vld & req_rdy;
    assign addr_err = |(req_addr & ERR_MASK);

    bb_v2_merge u_merge (
        .old_dat (v_out),
        .new_dat (lat_wdata),
        .be      (lat_be),
        .mrg_dat (mrg_dat)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_be    <= 4'h0;
            lat_wdata <= 32'h0;
        end else if (acc) begin
            lat_we    <= req_we;
            lat_err   <= addr_err;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (addr_err || (req_we && (req_be == 4'h0))) begin
                        state_d = ST_ACK;
                    end else if (!req_we) begin
                        state_d = ST_RD;
                    end else if (req_be == 4'hf) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD:      state_d = ST_RDCAP;
            ST_RMW_RD:  state_d = ST_RMW_CAP;
            ST_RMW_CAP: state_d = ST_RMW_WR;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered sram and response outputs.
    always_comb begin
        v_me_d     = 1'b0;
        v_we_d     = 1'b0;
        v_addr_d   = v_addr;
        v_in_d     = v_in;
        rsp_vld_d  = 1'b0;
        rsp_err_d  = 1'b0;
        rsp_data_d = rsp_data;
        case (state_q)
            ST_IDLE: begin
                if ((state_d == ST_RD) || (state_d == ST_RMW_RD)) begin
                    v_me_d   = 1'b1;
                    v_addr_d = req_addr;
                end else if (state_d == ST_WR) begin
                    v_me_d   = 1'b1;
                    v_we_d   = 1'b1;
                    v_addr_d = req_addr;
                    v_in_d   = req_wdata;
                end
            end
            ST_RMW_CAP: begin
                v_me_d = 1'b1;
                v_we_d = 1'b1;
                v_in_d = mrg_dat;
            end
            ST_RDCAP: begin
                rsp_vld_d  = 1'b1;
                rsp_data_d = v_out;
            end
            ST_WR, ST_RMW_WR: begin
                rsp_vld_d = 1'b1;
            end
            ST_ACK: begin
                rsp_vld_d = 1'b1;
                rsp_err_d = lat_err;
                if (lat_err && !lat_we) begin
                    rsp_data_d = 32'h0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            v_me     <= 1'b0;
            v_we     <= 1'b0;
            v_addr   <= '0;
            v_in     <= 32'h0;
            rsp_vld  <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_data <= 32'h0;
        end else begin
            v_me     <= v_me_d;
            v_we     <= v_we_d;
            v_addr   <= v_addr_d;
            v_in     <= v_in_d;
            rsp_vld  <= rsp_vld_d;
            rsp_err  <= rsp_err_d;
            rsp_data <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_bb_v2_ctrl.sv
// Bench for bb_v2_ctrl: sram model, transaction-level reference model, directed and random traffic.
module tb_bb_v2_ctrl;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic        req_we = 1'b0;
    logic [13:0] req_addr = 14'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        rsp_vld;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        v_me;
    logic        v_we;
    logic [13:0] v_addr;
    logic [31:0] v_in;
    logic [31:0] v_out;

    always #5 clk = ~clk;

    bb_v2_ctrl dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_vld   (rsp_vld),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .v_me      (v_me),
        .v_we      (v_we),
        .v_addr    (v_addr),
        .v_in      (v_in),
        .v_out     (v_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // sram: sampled at posedge, read data the cycle after, write commits at the following negedge.
    logic [31:0] sram [64];
    logic        pend_we;
    logic [5:0]  pend_a;
    logic [31:0] pend_d;

    initial for (int i = 0; i < 64; i++) sram[i] = 32'h0;

    always @(posedge clk) begin
        if (v_me && !v_we) v_out <= sram[v_addr[5:0]];
        pend_we <= v_me && v_we;
        pend_a  <= v_addr[5:0];
        pend_d  <= v_in;
    end

    always @(negedge clk) if (pend_we) sram[pend_a] = pend_d;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one outstanding transaction described by latency and per-cycle access masks.
    logic [31:0] model_mem [64];
    logic        busy = 1'b0;
    int          e0 = 0;
    int          t_lat = 1;
    int          k;
    logic [3:0]  me_m, we_m;
    logic        t_err, t_upd, t_commit;
    logic [13:0] t_addr;
    logic [31:0] t_rdata, t_wval;
    logic [31:0] exp_data = 32'h0;
    logic        e_rdy, e_vld, e_me, e_we, e_err;

    initial for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;

    always @(negedge clk) begin
        if (!reset_l) begin
            busy     = 1'b0;
            exp_data = 32'h0;
        end else begin
            e_rdy = 1'b1; e_vld = 1'b0; e_me = 1'b0; e_we = 1'b0; e_err = 1'b0;
            if (busy) begin
                k     = cyc - e0;
                e_rdy = (k >= t_lat);
                e_vld = (k == t_lat);
                if (k < 4) begin
                    e_me = me_m[k[1:0]];
                    e_we = we_m[k[1:0]];
                end
                if (k == t_lat) begin
                    e_err = t_err;
                    if (t_upd) exp_data = t_rdata;
                    if (t_commit) model_mem[t_addr[5:0]] = t_wval;
                    busy = 1'b0;
                end
            end
            check("req_rdy", req_rdy, e_rdy);
            check("rsp_vld", rsp_vld, e_vld);
            check("rsp_err", rsp_vld ? rsp_err : 1'b0, e_err);
            check("rsp_data", rsp_data, exp_data);
            check("v_me", v_me, e_me);
            check("v_we", v_we, e_we);
            if (e_me) check("v_addr", v_addr, t_addr);
            if (e_we) check("v_in", v_in, t_wval);
            if (req_vld && e_rdy) begin
                t_addr = req_addr; t_err = |req_addr[13:6];
                t_upd = 1'b0; t_commit = 1'b0; me_m = 4'h0; we_m = 4'h0;
                t_rdata = exp_data; t_wval = 32'h0; t_lat = 1;
                if (t_err) begin
                    if (!req_we) begin t_upd = 1'b1; t_rdata = 32'h0; end
                end else if (!req_we) begin
                    t_lat = 2; me_m = 4'b0001; t_upd = 1'b1; t_rdata = model_mem[req_addr[5:0]];
                end else if (req_be == 4'hf) begin
                    me_m = 4'b0001; we_m = 4'b0001; t_commit = 1'b1; t_wval = req_wdata;
                end else if (req_be != 4'h0) begin
                    t_lat = 3; me_m = 4'b0101; we_m = 4'b0100; t_commit = 1'b1;
                    for (int n = 0; n < 4; n++)
                        t_wval[8*n +: 8] = req_be[n] ? req_wdata[8*n +: 8] : model_mem[req_addr[5:0]][8*n +: 8];
                end
                busy = 1'b1;
                e0   = cyc + 1;
            end
        end
    end

    task automatic scramble();
        req_vld   = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 14'($urandom);
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // Called at posedge+2; returns at posedge+2 of the accepting edge with req_vld still high.
    task automatic issue(input logic we, input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
        logic got;
        got = 1'b0;
        req_vld = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #2;
            if (busy && (e0 == cyc)) got = 1'b1;
        end
        check("accept", got, 1'b1);
        if (!got) req_vld = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er, output logic [3:0] mep);
        lat = -1; rd = 32'h0; er = 1'b0; mep = 4'h0;
        for (int n = 0; n < 8 && lat < 0; n++) begin
            @(negedge clk);
            if (n < 4) mep[n[1:0]] = v_me;
            if (rsp_vld) begin lat = n; rd = rsp_data; er = rsp_err; end
        end
        if (lat < 0) check("rsp_timeout", 32'hffffffff, 32'h0);
    endtask

    task automatic xact(input logic we, input logic [13:0] a, input logic [31:0] d, input logic [3:0] be,
                        output int lat, output logic [31:0] rd, output logic er, output logic [3:0] mep);
        issue(we, a, d, be);
        scramble();
        wait_rsp(lat, rd, er, mep);
        @(posedge clk); #2;
    endtask

    task automatic reset_pulse();
        repeat (2) @(posedge clk);
        #2 reset_l = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", req_rdy, 1'b1);
        check("vld_after_rst", rsp_vld, 1'b0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("no_spurious_vld", rsp_vld, 1'b0);
        end
        @(posedge clk); #2;
    endtask

    int          lat, c1, c2, c3, gap;
    logic [31:0] rd;
    logic        er;
    logic [3:0]  mep, rbe;
    logic [13:0] ra;

    initial begin
        #12;
        check("rst_v_me", v_me, 1'b0);
        check("rst_rsp_vld", rsp_vld, 1'b0);
        #10 reset_l = 1'b1;
        @(posedge clk); #2;
        check("rst_req_rdy", req_rdy, 1'b1);
        check("rst_v_we", v_we, 1'b0);
        check("rst_v_addr", v_addr, 14'h0);
        check("rst_v_in", v_in, 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);

        xact(1'b1, 14'h05, 32'hdeadbeef, 4'hf, lat, rd, er, mep);
        check("wr_lat", lat, 1); check("wr_err", er, 1'b0); check("wr_me", mep, 4'b0001);
        xact(1'b0, 14'h05, 32'h0, 4'h0, lat, rd, er, mep);
        check("rd_lat", lat, 2); check("rd_data", rd, 32'hdeadbeef);

        xact(1'b1, 14'h10, 32'h11223344, 4'hf, lat, rd, er, mep);
        xact(1'b1, 14'h10, 32'haabbccdd, 4'b0101, lat, rd, er, mep);
        check("rmw_lat", lat, 3); check("rmw_me", mep, 4'b0101); check("rmw_err", er, 1'b0);
        xact(1'b0, 14'h10, 32'h0, 4'h0, lat, rd, er, mep);
        check("rmw_data", rd, 32'h11bb33dd);

        xact(1'b1, 14'h00, 32'h0badf00d, 4'hf, lat, rd, er, mep);
        xact(1'b1, 14'h0100, 32'hffffffff, 4'hf, lat, rd, er, mep);
        check("errw_lat", lat, 1); check("errw_err", er, 1'b1);
        check("errw_data", rd, 32'h11bb33dd); check("errw_me", mep, 4'h0);
        xact(1'b0, 14'h0100, 32'h0, 4'h0, lat, rd, er, mep);
        check("errr_lat", lat, 1); check("errr_err", er, 1'b1);
        check("errr_data", rd, 32'h0); check("errr_me", mep, 4'h0);
        xact(1'b0, 14'h00, 32'h0, 4'h0, lat, rd, er, mep);
        check("word0_kept", rd, 32'h0badf00d);

        xact(1'b1, 14'h3f, 32'h12345678, 4'hf, lat, rd, er, mep);
        xact(1'b1, 14'h3f, 32'h0, 4'h0, lat, rd, er, mep);
        check("be0_lat", lat, 1); check("be0_err", er, 1'b0); check("be0_me", mep, 4'h0);
        xact(1'b0, 14'h3f, 32'h0, 4'h0, lat, rd, er, mep);
        check("be0_data", rd, 32'h12345678);

        xact(1'b1, 14'h00, 32'ha5a5a5a5, 4'hf, lat, rd, er, mep);
        xact(1'b1, 14'h3f, 32'h5a5a5a5a, 4'hf, lat, rd, er, mep);
        issue(1'b0, 14'h00, 32'h0, 4'h0); c1 = cyc;
        check("b2b_rdy_rd", req_rdy, 1'b0);
        @(posedge clk); #2;
        check("b2b_rdy_rdcap", req_rdy, 1'b0);
        issue(1'b0, 14'h3f, 32'h0, 4'h0); c2 = cyc;
        issue(1'b0, 14'h00, 32'h0, 4'h0); c3 = cyc;
        scramble();
        wait_rsp(lat, rd, er, mep);
        check("b2b_gap1", c2 - c1, 3); check("b2b_gap2", c3 - c2, 3);
        check("b2b_data", rd, 32'ha5a5a5a5);
        @(posedge clk); #2;

        issue(1'b1, 14'h10, 32'hffffffff, 4'b0011);
        scramble();
        @(posedge clk); #2;
        reset_l = 1'b0;
        #1;
        check("rstcap_v_me", v_me, 1'b0); check("rstcap_v_we", v_we, 1'b0);
        check("rstcap_rsp_vld", rsp_vld, 1'b0); check("rstcap_rsp_data", rsp_data, 32'h0);
        reset_pulse();
        xact(1'b0, 14'h10, 32'h0, 4'h0, lat, rd, er, mep);
        check("rstcap_data", rd, 32'h11bb33dd);

        issue(1'b1, 14'h20, 32'hffffffff, 4'b1000);
        scramble();
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("rmwwr_v_me", v_me, 1'b1); check("rmwwr_v_we", v_we, 1'b1);
        reset_l = 1'b0;
        #1;
        check("rstwr_v_me", v_me, 1'b0); check("rstwr_v_we", v_we, 1'b0);
        reset_pulse();
        xact(1'b0, 14'h20, 32'h0, 4'h0, lat, rd, er, mep);
        check("rstwr_data", rd, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) ra = {8'($urandom_range(1, 255)), 6'($urandom)};
            else if ($urandom_range(0, 1) == 0) ra = 14'($urandom_range(0, 7));
            else ra = 14'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0: rbe = 4'hf;
                1: rbe = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'hf;
                default: rbe = 4'($urandom);
            endcase
            issue(1'($urandom), ra, $urandom, rbe);
            if ($urandom_range(0, 2) != 0) begin
                scramble();
                gap = $urandom_range(0, 3);
                repeat (gap) begin @(posedge clk); #2; end
            end
        end
        scramble();
        repeat (6) begin @(posedge clk); #2; end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bb_v2_ctrl.md
Name: bb_v2_ctrl

Overview:
- Request sequencer in the MI that drives the 64x32 virage sram wrapper's v_me/v_we/v_addr/v_in ports.
- Captures v_out into a flop in the cycle after the access.
- Accepts single-beat register-bus requests.
- Sram has no byte enables, so partial writes are done as read-modify-write.
- Flags out-of-range addresses without touching the sram.

Parameters:
- ADDR_BITS, 6, word-address bits implemented in sram (64 words).
- ADDR_HI, 15, top bit of request word address [ADDR_HI:2].

Ports:
- clk  in  1  system clock; also drives the sram's v_clk.
- reset_l  in  1  asynchronous active-low reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  controller idle; request accepted on posedge when req_vld & req_rdy.
- req_we  in  1  1=write, 0=read.
- req_addr  in  14  word address [15:2].
- req_wdata  in  32  write data.
- req_be  in  4  byte enables, bit n = byte [8n+7:8n].
- rsp_vld  out  1  one-cycle completion pulse, for reads and writes.
- rsp_data  out  32  read data; valid with rsp_vld on reads; held until next read completes.
- rsp_err  out  1  address out of range; valid with rsp_vld.
- v_me  out  1  sram enable (registered).
- v_we  out  1  sram write enable (registered).
- v_addr  out  14  sram address [15:2] (registered).
- v_in  out  32  sram write data (registered).
- v_out  in  32  sram read data; valid the cycle after the wrapper samples v_me=1.

Behaviour:
- Reset, asynchronous, reset_l=0:
  - state=IDLE.
  - v_me=0, v_we=0, v_addr=0, v_in=0.
  - rsp_vld=0, rsp_err=0, rsp_data=0.
  - req_rdy=1 once reset is released.
- req_rdy = (state==IDLE); decoded from flops, no combinational path from req_vld.
- Range check: req_addr[15:8]!=0 is an error.
- States: IDLE, RD, RDCAP, WR, RMW_RD, RMW_CAP, RMW_WR, ACK.
- Accept at edge E0, by request type:
  - Error address → ACK. No sram access. At E1: rsp_vld=1, rsp_err=1; rsp_data unchanged for writes, forced to 0 for reads.
  - Write with be==4'h0 → ACK. No sram access. rsp_vld at E1, rsp_err=0.
  - Write with be==4'hf → WR. At E0: v_me=1, v_we=1, v_addr=req_addr, v_in=req_wdata. At E1: v_me=0, v_we=0, rsp_vld=1, state IDLE. The sram commits at the falling edge after E1.
  - Read → RD. At E0: v_me=1, v_we=0, v_addr=req_addr. At E1: v_me=0, state RDCAP. At E2: rsp_data=v_out, rsp_vld=1, state IDLE. Read latency is 2 clocks from acceptance.
  - Partial write, other be values → RMW_RD. Read phase as above (E0, E1). At E2, per byte: merged = be[n] ? req_wdata byte : v_out byte. Drive v_me=1, v_we=1, v_in=merged; state RMW_WR. At E3: v_me=0, v_we=0, rsp_vld=1, state IDLE. rsp_data is not updated by a partial write.
- Request fields are latched at acceptance; req_* may change afterwards.
- v_addr and v_in hold their last values while v_me=0.
- Back-to-back traffic:
  - Earliest next acceptance is the edge after rsp_vld rises.
  - Read-after-write to the same address returns the new data, because the write commits at the negedge before the read's sampling edge.
- rsp_vld is never high for two consecutive cycles.
- Reset mid-operation: all flops clear immediately. The in-flight request is dropped, with no rsp_vld. A partial write may or may not have committed; software re-issues.
- v_we is never 1 while v_me is 0.

Decomposition:
- Package bb_v2_pkg:
  - state encoding constants, 3-bit.
  - V2_WORDS=64, V2_ADDR_BITS=6.
  - error-range mask constant.
- Sub-module bb_v2_merge: combinational 4-byte merge of v_out and write data under be.

Test Plan:
- Full write addr 14'h05, data 32'hdeadbeef, be=f; then read 14'h05 → rsp_vld 1 clk after write acceptance; read rsp_data=32'hdeadbeef, rsp_vld exactly 2 clks after read acceptance.
- Preload word 14'h10=32'h11223344; write be=4'b0101, data 32'haabbccdd; read back → 32'h11bb33dd; write rsp_vld at E3; v_me high exactly in cycles E0 and E2.
- Read 14'h0100 (out of range) → rsp_vld at E1, rsp_err=1, rsp_data=0, v_me never asserted; same for a write, with sram word 0 unchanged.
- Write be=4'h0 to 14'h3f → rsp_vld at E1, rsp_err=0, no v_me; read 14'h3f shows the old value.
- Wrap/boundary: write to 14'h00 and 14'h3f, then back-to-back reads with req_vld held high → each read completes in 3 cycles; data correct; req_rdy low during RD/RDCAP.
- Assert reset_l=0 during RMW_CAP → v_me, v_we, rsp_vld go 0 immediately with no clock; after release req_rdy=1 and no spurious rsp_vld.
